// File: rtl/io_timer_pkg.sv
// io_timer_pkg
// Shared definitions for the io_timer peripheral: register offsets inside the
// 8-byte IO window, CTRL bit positions, prescaler select encodings and the
// prescaler terminal-count table.
package io_timer_pkg;

    // Register offsets (address[2:0])
    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_CMP_L = 3'd1;
    localparam logic [2:0] OFF_CMP_H = 3'd2;
    localparam logic [2:0] OFF_CNT_L = 3'd3;
    localparam logic [2:0] OFF_CNT_H = 3'd4;
    localparam logic [2:0] OFF_STAT  = 3'd5;

    // CTRL bit indices
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_CTC   = 1;
    localparam int unsigned CTRL_MIE   = 2;
    localparam int unsigned CTRL_OIE   = 3;
    localparam int unsigned CTRL_PS_LO = 4;
    localparam int unsigned CTRL_PS_HI = 5;

    // STAT bit indices
    localparam int unsigned STAT_MATCH = 0;
    localparam int unsigned STAT_OVF   = 1;

    // Prescaler select encodings
    typedef enum logic [1:0] {
        PS_DIV1   = 2'b00,
        PS_DIV8   = 2'b01,
        PS_DIV64  = 2'b10,
        PS_DIV256 = 2'b11
    } psSel_t;

    // Terminal count (divisor - 1) for a prescaler select value
    function automatic logic [7:0] prescTop(input psSel_t ps);
        logic [7:0] top;
        case (ps)
            PS_DIV1:   top = 8'd0;
            PS_DIV8:   top = 8'd7;
            PS_DIV64:  top = 8'd63;
            PS_DIV256: top = 8'd255;
            default:   top = 8'd0;
        endcase
        return top;
    endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// timer_prescaler
// 8-bit prescaler producing a one-cycle tick every 1/8/64/256 enabled cycles.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : count enable; the counter is held at 0 while low
//   ps       : prescaler select (00=/1, 01=/8, 10=/64, 11=/256)
//   clear    : restart the prescale period (counter write)
//   tick     : one-cycle count strobe
module timer_prescaler
    import io_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] ps,
    input  logic       clear,
    output logic       tick
);

    logic [7:0] presc;

    assign tick = en && (presc == prescTop(psSel_t'(ps)));

    always_ff @(posedge clk) begin
        if (rst || !en || clear) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 8'd1;
        end
    end

endmodule

// File: rtl/io_timer.sv
// io_timer
// Memory-mapped 16-bit timer/counter on the CPU IO bus with prescaler,
// compare-match auto-clear (CTC), overflow flag and level interrupt.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   address       : CPU IO address; window BASE_ADDR..BASE_ADDR+5
//   data_in       : CPU write data
//   data_out      : registered read data, 0 when no read was decoded
//   write_en      : CPU write strobe
//   read_en       : CPU read strobe
//   interrupt     : level request = MIE&MATCH | OIE&OVF
//   interrupt_clr : clears MATCH and OVF
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        write_en,
    input  logic        read_en,
    output logic        interrupt,
    input  logic        interrupt_clr
);

    logic [5:0]  ctrl;
    logic [15:0] cmp;
    logic [15:0] cnt;
    logic        matchFlag;
    logic        ovfFlag;
    logic [7:0]  wrTmp;
    logic [7:0]  rdTmp;

    logic [2:0]  offset;
    logic        sel;
    logic        wrSel;
    logic        rdSel;
    logic        cntLoad;
    logic        tick;
    logic        matchSet;
    logic        ovfSet;
    logic        matchClr;
    logic        ovfClr;
    logic [15:0] cntNext;
    logic [7:0]  rdData;

    assign offset  = address[2:0];
    assign sel     = (address[15:3] == BASE_ADDR[15:3]) && (offset <= OFF_STAT);
    assign wrSel   = write_en && sel;
    assign rdSel   = read_en && sel;
    assign cntLoad = wrSel && (offset == OFF_CNT_L);

    assign matchClr = interrupt_clr || (wrSel && (offset == OFF_STAT) && data_in[STAT_MATCH]);
    assign ovfClr   = interrupt_clr || (wrSel && (offset == OFF_STAT) && data_in[STAT_OVF]);

    assign interrupt = (ctrl[CTRL_MIE] & matchFlag) | (ctrl[CTRL_OIE] & ovfFlag);

    timer_prescaler uPresc (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl[CTRL_EN]),
        .ps    (ctrl[CTRL_PS_HI:CTRL_PS_LO]),
        .clear (cntLoad),
        .tick  (tick)
    );

    // A counter load in the same cycle suppresses the tick entirely.
    // Overflow only reaches the else branch when CTC did not match, so the
    // CTC && cmp==FFFF exclusion collapses to a plain cnt==FFFF test there.
    always_comb begin
        cntNext  = cnt;
        matchSet = 1'b0;
        ovfSet   = 1'b0;
        if (tick && !cntLoad) begin
            if (ctrl[CTRL_CTC] && (cnt == cmp)) begin
                cntNext  = '0;
                matchSet = 1'b1;
            end else begin
                cntNext  = cnt + 16'd1;
                matchSet = (cnt == cmp);
                ovfSet   = (cnt == '1);
            end
        end
    end

    always_comb begin
        rdData = '0;
        case (offset)
            OFF_CTRL:  rdData = {2'b00, ctrl};
            OFF_CMP_L: rdData = cmp[7:0];
            OFF_CMP_H: rdData = cmp[15:8];
            OFF_CNT_L: rdData = cnt[7:0];
            OFF_CNT_H: rdData = rdTmp;
            OFF_STAT:  rdData = {6'b0, ovfFlag, matchFlag};
            default:   rdData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            cmp       <= '0;
            cnt       <= '0;
            matchFlag <= 1'b0;
            ovfFlag   <= 1'b0;
            wrTmp     <= '0;
            rdTmp     <= '0;
            data_out  <= '0;
        end else begin
            data_out <= rdSel ? rdData : '0;

            // Latch the high byte at the low-byte read for a coherent pair
            if (rdSel && (offset == OFF_CNT_L)) begin
                rdTmp <= cnt[15:8];
            end

            if (wrSel) begin
                case (offset)
                    OFF_CTRL:  ctrl  <= data_in[5:0];
                    OFF_CMP_L: cmp   <= {wrTmp, data_in};
                    OFF_CMP_H: wrTmp <= data_in;
                    OFF_CNT_H: wrTmp <= data_in;
                    default:   ;
                endcase
            end

            cnt <= cntLoad ? {wrTmp, data_in} : cntNext;

            // Setting beats clearing in the same cycle
            matchFlag <= matchSet | (matchFlag & ~matchClr);
            ovfFlag   <= ovfSet   | (ovfFlag   & ~ovfClr);
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer
// Bench for io_timer: directed scenarios followed by random bus traffic, with
// every cycle's data_out and interrupt compared against a behavioural model.
module tb_io_timer;

    localparam logic [15:0] BASE = 16'h1000;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        write_en;
    logic        read_en;
    logic        interrupt;
    logic        interrupt_clr;

    int checks   = 0;
    int failures = 0;

    io_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .data_in       (data_in),
        .data_out      (data_out),
        .write_en      (write_en),
        .read_en       (read_en),
        .interrupt     (interrupt),
        .interrupt_clr (interrupt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit          mEn, mCtc, mMie, mOie;
    int          mPs;
    int          mCmp, mCnt, mWrTmp, mRdTmp, mDout;
    bit          mMatch, mOvf;
    int          mPhase;   // enabled cycles elapsed in current prescale period

    function automatic int divisorOf(input int ps);
        int table_[4] = '{1, 8, 64, 256};
        return table_[ps];
    endfunction

    function automatic bit modelIrq();
        return (mMie && mMatch) || (mOie && mOvf);
    endfunction

    task automatic modelReset();
        mEn = 0; mCtc = 0; mMie = 0; mOie = 0; mPs = 0;
        mCmp = 0; mCnt = 0; mWrTmp = 0; mRdTmp = 0; mDout = 0;
        mMatch = 0; mOvf = 0; mPhase = 0;
    endtask

    // Advance the model by one clock given this cycle's bus inputs
    task automatic modelStep(input bit r, input int a, input int d,
                             input bit we, input bit re, input bit ic);
        int  off;
        bit  inWin, isTick, load, setM, setO, clrM, clrO;
        int  rv, nCnt;
        if (r) begin
            modelReset();
            return;
        end
        off   = a % 8;
        inWin = (a / 8 == BASE / 8) && (off < 6);
        isTick = mEn && (mPhase + 1 == divisorOf(mPs));
        load  = we && inWin && off == 3;

        case (off)
            0: rv = mEn + 2*mCtc + 4*mMie + 8*mOie + 16*mPs;
            1: rv = mCmp % 256;
            2: rv = mCmp / 256;
            3: rv = mCnt % 256;
            4: rv = mRdTmp;
            5: rv = mMatch + 2*mOvf;
            default: rv = 0;
        endcase

        setM = 0; setO = 0; nCnt = mCnt;
        if (load) begin
            nCnt = mWrTmp * 256 + d;
        end else if (isTick) begin
            if (mCtc && mCnt == mCmp) begin
                nCnt = 0;
                setM = 1;
            end else begin
                setM = (mCnt == mCmp);
                setO = (mCnt == 65535);
                nCnt = (mCnt + 1) % 65536;
            end
        end

        clrM = ic || (we && inWin && off == 5 && (d % 2 == 1));
        clrO = ic || (we && inWin && off == 5 && ((d / 2) % 2 == 1));

        if (!mEn || load || isTick) mPhase = 0;
        else mPhase = mPhase + 1;

        mDout = (re && inWin) ? rv : 0;
        if (re && inWin && off == 3) mRdTmp = mCnt / 256;

        if (we && inWin) begin
            case (off)
                0: begin
                    mEn = d[0]; mCtc = d[1]; mMie = d[2]; mOie = d[3];
                    mPs = (d / 16) % 4;
                end
                1: mCmp = mWrTmp * 256 + d;
                2, 4: mWrTmp = d;
                default: ;
            endcase
        end
        mCnt = nCnt;
        mMatch = setM ? 1'b1 : (clrM ? 1'b0 : mMatch);
        mOvf   = setO ? 1'b1 : (clrO ? 1'b0 : mOvf);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, update model, clock, compare outputs
    task automatic step(input bit r, input logic [15:0] a, input logic [7:0] d,
                        input bit we, input bit re, input bit ic);
        rst = r; address = a; data_in = d;
        write_en = we; read_en = re; interrupt_clr = ic;
        modelStep(r, int'(a), int'(d), we, re, ic);
        @(posedge clk);
        #1;
        chk("model_dout", {8'h00, data_out}, mDout[15:0]);
        chk("model_irq", {15'h0, interrupt}, {15'h0, modelIrq()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0000, 8'h00, 0, 0, 0);
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        step(0, BASE + {13'h0, off}, d, 1, 0, 0);
    endtask

    task automatic rd(input logic [2:0] off);
        step(0, BASE + {13'h0, off}, 8'h00, 0, 1, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rdv;
        bit          rr, rwe, rre, ric;

        modelReset();
        rst = 1; address = '0; data_in = '0;
        write_en = 0; read_en = 0; interrupt_clr = 0;

        // Reset state
        step(1, 16'h0000, 8'h00, 0, 0, 0);
        step(1, 16'h0000, 8'h00, 0, 0, 0);
        chk("reset_dout", {8'h00, data_out}, 16'h0000);
        chk("reset_irq", {15'h0, interrupt}, 16'h0000);

        // Register access
        wr(3'd2, 8'h12);
        wr(3'd1, 8'h34);
        rd(3'd1);
        chk("cmpL_read", {8'h00, data_out}, 16'h0034);
        rd(3'd2);
        chk("cmpH_read", {8'h00, data_out}, 16'h0012);
        idle(1);
        chk("dout_idle_zero", {8'h00, data_out}, 16'h0000);
        step(0, 16'h2001, 8'h00, 0, 1, 0);
        chk("unselected_read", {8'h00, data_out}, 16'h0000);
        wr(3'd6, 8'hAA);
        rd(3'd6);
        chk("offset6_read", {8'h00, data_out}, 16'h0000);

        // CTC match: cnt 0,1,2,3,4,0
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h04);
        wr(3'd0, 8'h07);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("ctc_no_irq_yet", {15'h0, interrupt}, 16'h0000);
        end
        idle(1);
        chk("ctc_match_irq", {15'h0, interrupt}, 16'h0001);
        rd(3'd3);
        chk("ctc_cnt_restart", {8'h00, data_out}, 16'h0000);
        step(0, 16'h0000, 8'h00, 0, 0, 1);
        chk("ctc_irq_cleared", {15'h0, interrupt}, 16'h0000);
        wr(3'd0, 8'h00);

        // Overflow
        wr(3'd4, 8'hFF);
        wr(3'd3, 8'hFE);
        wr(3'd0, 8'h09);
        idle(1);
        chk("ovf_not_yet", {15'h0, interrupt}, 16'h0000);
        idle(1);
        chk("ovf_irq", {15'h0, interrupt}, 16'h0001);
        rd(3'd5);
        chk("ovf_stat", {8'h00, data_out}, 16'h0002);
        wr(3'd5, 8'h02);
        chk("ovf_w1c", {15'h0, interrupt}, 16'h0000);
        wr(3'd0, 8'h00);

        // Prescaler /8
        wr(3'd4, 8'h00);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h11);
        idle(8);
        rd(3'd3);
        chk("presc8_cnt1", {8'h00, data_out}, 16'h0001);
        idle(15);
        rd(3'd3);
        chk("presc8_cnt3", {8'h00, data_out}, 16'h0003);
        wr(3'd0, 8'h10);
        idle(40);
        rd(3'd3);
        chk("freeze_cnt", {8'h00, data_out}, 16'h0003);

        // Coherent 16-bit read across a carry
        wr(3'd4, 8'h00);
        wr(3'd3, 8'hFF);
        wr(3'd0, 8'h01);
        rd(3'd3);
        chk("coh_low", {8'h00, data_out}, 16'h00FF);
        rd(3'd4);
        chk("coh_high_latched", {8'h00, data_out}, 16'h0000);
        wr(3'd0, 8'h00);

        // Match tick coincident with interrupt_clr
        wr(3'd4, 8'h00);
        wr(3'd3, 8'h03);
        wr(3'd0, 8'h05);
        idle(1);
        step(0, 16'h0000, 8'h00, 0, 0, 1);
        chk("set_beats_clr", {15'h0, interrupt}, 16'h0001);
        step(0, 16'h0000, 8'h00, 0, 0, 1);
        chk("clr_after_set", {15'h0, interrupt}, 16'h0000);

        // Reset mid-count
        idle(3);
        step(1, BASE + 16'd3, 8'h00, 0, 1, 0);
        chk("midrst_dout", {8'h00, data_out}, 16'h0000);
        chk("midrst_irq", {15'h0, interrupt}, 16'h0000);
        for (int o = 0; o < 6; o++) begin
            rd(3'(o));
            chk("midrst_reg_zero", {8'h00, data_out}, 16'h0000);
        end

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 499) == 0);
            ric = ($urandom_range(0, 19) == 0);
            rwe = ($urandom_range(0, 3) == 0);
            rre = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) ra = 16'($urandom);
            else ra = BASE + 16'($urandom_range(0, 7));
            rdv = 8'($urandom);
            if (ra[2:0] == 3'd0 && $urandom_range(0, 1) == 0) rdv[5:4] = 2'b00;
            if ((ra[2:0] == 3'd2 || ra[2:0] == 3'd4) && $urandom_range(0, 1) == 0) rdv = 8'hFF;
            step(rr, ra, rdv, rwe, rre, ric);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped 16-bit timer/counter peripheral; the responder on the CPU data-memory/IO bus.
- Decodes CPU IO-space accesses and answers reads with one-cycle registered latency.
- Counts prescaled clock ticks, supports compare-match auto-clear (CTC) and overflow.
- Raises a level interrupt into one of the CPU interrupt lines and drops it when the CPU pulses the matching clear output.

Parameters:
- BASE_ADDR, 16'h1000, address of register 0; the block decodes BASE_ADDR..BASE_ADDR+5, with BASE_ADDR 8-aligned.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- address  input  16  CPU dMemIOAddress.
- data_in  input  8  CPU write data (dMemIOIn).
- data_out  output  8  read data to the system read mux (feeds dMemIOOut).
- write_en  input  1  CPU dMemIOWriteEn.
- read_en  input  1  CPU dMemIOReadEn.
- interrupt  output  1  level interrupt request to a CPU interrupt_N input.
- interrupt_clr  input  1  CPU interrupt_N_clr pulse.

Behaviour:
- Reset values: all registers, prescaler, temporaries, data_out and interrupt are 0. Reset mid-count aborts counting with no flag set.
- Register offsets:
  - 0 CTRL (R/W): bit0 EN, bit1 CTC, bit2 MIE, bit3 OIE, bits5:4 PS, bits7:6 read 0.
  - 1 CMP_L, 2 CMP_H.
  - 3 CNT_L, 4 CNT_H.
  - 5 STAT: bit0 MATCH, bit1 OVF; write-1-to-clear; other bits read 0.
- Select: sel = (address[15:3] == BASE_ADDR[15:3]) and address[2:0] <= 5. Offsets 6 and 7 are ignored: writes have no effect, reads return 0.
- Read timing: if read_en && sel in cycle N, data_out = register value sampled in cycle N, valid in cycle N+1. In every other cycle data_out = 8'h00, so the system can OR-mux it.
- 16-bit coherency:
  - Writing CMP_H or CNT_H stores the byte in wr_tmp only.
  - Writing CMP_L commits cmp <= {wr_tmp, data_in}.
  - Writing CNT_L commits cnt <= {wr_tmp, data_in} and clears the prescaler.
  - Reading CNT_L returns cnt[7:0] and latches rd_tmp <= cnt[15:8]. Reading CNT_H returns rd_tmp.
  - CMP_H reads return cmp[15:8] directly.
- Prescaler: 8-bit counter, held at 0 while EN = 0.
  - Divisor from PS: 00 = 1, 01 = 8, 10 = 64, 11 = 256.
  - tick = EN && (presc == divisor-1); presc wraps to 0 on tick, otherwise increments.
  - PS = 00 gives tick every cycle while EN = 1.
- Counter update on tick, in priority order:
  - CTC && cnt == cmp: cnt <= 0, MATCH <= 1.
  - else if cnt == cmp: MATCH <= 1, cnt <= cnt+1 (wraps).
  - Independently, cnt == 16'hFFFF && !(CTC && cmp == 16'hFFFF): OVF <= 1, cnt wraps to 0.
  - CTC with cmp = FFFF therefore sets MATCH only.
- Simultaneous events:
  - A CNT_L write in the same cycle as a tick wins; no increment and no flags from that tick.
  - A flag set in the same cycle as a STAT W1C or interrupt_clr wins; the flag stays 1.
- interrupt = (MIE & MATCH) | (OIE & OVF), combinational from registers only (no combinational path from bus inputs).
- interrupt_clr = 1 clears both MATCH and OVF in the next cycle, so interrupt falls one cycle after the clr pulse.
- Writing EN = 0 freezes cnt; flags and cmp are retained.

Decomposition:
- Shared package io_timer_pkg: register offset constants (CTRL..STAT), CTRL bit indices, PS encodings and divisor table.
- Sub-module timer_prescaler: EN, PS and clear in; tick out. Holds the 8-bit presc counter.

Test Plan:
- Register access: reset, then write CMP_H = 8'h12, CMP_L = 8'h34, then read CMP_L, CMP_H -> data_out 8'h34 then 8'h12, each one cycle after read_en; an unselected read returns 8'h00.
- CTC match: CMP = 16'h0004, CTRL = 8'h07 (EN, CTC, MIE, PS /1) -> cnt sequence 0,1,2,3,4,0; MATCH and interrupt assert the cycle after the tick at cnt = 4; interrupt_clr pulse drops interrupt one cycle later.
- Overflow: CNT = 16'hFFFE, CTRL = 8'h09 (EN, OIE) -> after 2 ticks cnt = 0000, OVF = 1, interrupt = 1; writing STAT = 8'h02 clears it.
- Prescaler: PS = 01, EN = 1 from cnt = 0 -> cnt = 1 exactly 8 cycles after EN, cnt = 3 after 24 cycles; EN = 0 then freezes cnt.
- Coherent read: cnt = 16'h00FF, read CNT_L (8'hFF), tick to 16'h0100, read CNT_H -> 8'h00 (latched value, not 8'h01).
- Collisions and reset: a match tick coincident with interrupt_clr -> MATCH stays 1; rst asserted mid-count -> all outputs and registers 0 next cycle.
